pr_bridge: RTL and testbench
============================

PR_BRIDGE -- requirements
Module: pr_bridge

Interface
REQ-001 Parameter TIMER_BASE, 32'h0000_7F00, word-aligned base of the internal timer window (3 words).
REQ-002 Parameter DEV_BASE, 32'h0000_7F10, word-aligned base of the external device window (3 words).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 PrAddr  input  32  CPU byte address; bits [1:0] ignored.
REQ-007 PrWD  input  32  CPU write data.
REQ-008 PrWE  input  1  CPU write enable.
REQ-009 PrRD  output  32  read data to the CPU.
REQ-010 HWInt  output  6 ([7:2])  interrupt lines to the CPU.
REQ-011 DevAddr  output  2  word offset within the device window (PrAddr[3:2]).
REQ-012 DevWD  output  32  write data to the device (PrWD).
REQ-013 DevWE  output  1  device write strobe.
REQ-014 DevRD  input  32  device read data.
REQ-015 DevInt  input  1  device interrupt request, level.

Function
REQ-016 Decode: hit when PrAddr[31:4] matches the window base and PrAddr[3:2] != 2'b11; the timer window is offsets 0 CTRL, 4 PRESET, 8 COUNT.
REQ-017 PrRD is combinational from the current PrAddr: timer register, DevRD, or 32'h0 when unmapped.
REQ-018 Writes commit at the clk edge when PrWE=1 and the address hits; writes to unmapped addresses and to COUNT are dropped.
REQ-019 DevWE = PrWE AND device hit; no other side effects.
REQ-020 HWInt[2] = timer IRQ; HWInt[3] = DevInt; HWInt[7:4] = 0.
REQ-021 Timer CTRL bits: [0] Enable, [2:1] Mode (00 one-shot, 01 auto-reload, others as 00), [3] IM; CTRL reads {28'b0, CTRL[3:0]}.
REQ-022 Timer FSM states: IDLE, LOAD, CNT, INT.
REQ-023 IDLE -> LOAD when Enable=1.
REQ-024 LOAD: COUNT <= PRESET; -> CNT.
REQ-025 CNT: if Enable=0 -> IDLE with COUNT held; else if COUNT > 1, COUNT <= COUNT-1; else COUNT <= 0 -> INT.
REQ-026 INT in one-shot mode: set irq_flag, clear Enable, -> IDLE; irq_flag holds until the next CTRL write.
REQ-027 INT in auto-reload mode: irq_flag is high for exactly one cycle; -> LOAD.
REQ-028 Timer IRQ = IM AND irq_flag.
REQ-029 PRESET=0 or 1 reaches INT two cycles after LOAD (LOAD, CNT, INT).
REQ-030 A PRESET write while counting takes effect only at the next LOAD.
REQ-031 A CTRL write in the same cycle as the INT-state Enable clear: the software value wins.
REQ-032 A CTRL write clears irq_flag.

Reset
REQ-033 Reset clears CTRL, PRESET, COUNT and irq_flag to 0 and sets the FSM to IDLE; it is effective immediately mid-count.
REQ-034 During reset, HWInt = 6'b0 and DevWE = 0; PrRD follows decode, so timer addresses read 0.

Configuration
REQ-035 Macro PR_BRIDGE_DEV_EN: when defined, the device window is decoded per REQ-016..020.
REQ-036 When PR_BRIDGE_DEV_EN is undefined, the Dev ports still exist, but DevWE=0, DevAddr=0, DevWD=0, device reads return 0, and HWInt[3]=0.

Structure
REQ-037 A shared package pr_bridge_pkg holds the default base addresses, register offsets, CTRL bit positions, Mode encodings, and the timer state enum.
REQ-038 The timer is a sub-module, pr_timer (clk, reset, Addr[3:2], WE, WD, RD, IRQ); pr_bridge holds only decode, mux and interrupt wiring.

Verification
REQ-039 Write PRESET=3, then CTRL=32'h9 (Enable, one-shot, IM) -> COUNT reads 3,2,1,0 on successive cycles after LOAD; HWInt[2] rises after COUNT=0 and stays high; CTRL reads 32'h8.
REQ-040 PRESET=2, CTRL=32'hB (auto-reload, IM) -> HWInt[2] pulses one cycle every 4 cycles (LOAD, CNT x2, INT) for 3 periods.
REQ-041 Enable cleared mid-count at COUNT=5 -> FSM goes to IDLE, COUNT holds 5, and no IRQ occurs.
REQ-042 Write 32'hDEAD to DEV_BASE+8 with DevInt=1 -> DevWE high one cycle, DevAddr=2, DevWD=32'hDEAD, HWInt=6'b000010; repeat without PR_BRIDGE_DEV_EN -> DevWE=0, HWInt[3]=0.
REQ-043 Read 32'h7F0C and write 32'h1 to COUNT -> PrRD=0 and COUNT is unchanged.
REQ-044 Assert reset asynchronously mid-count with IRQ high -> HWInt and all timer registers read 0 before the next clk edge.

Source files
------------

// File: rtl/pr_bridge_pkg.sv
// Shared definitions for the processor bridge and its interval timer:
// default window bases, register word offsets, CTRL bit positions,
// Mode encodings and the timer state enum.
package pr_bridge_pkg;

  localparam logic [31:0] TIMER_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] DEV_BASE_DEF   = 32'h0000_7F10;

  // Word offsets inside a 3-word window (offset 3 is a hole)
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  // Mode encodings; anything other than auto-reload behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_e;

  // A 3-word window hits on its 16-byte block, excluding the last word.
  function automatic logic win_hit(input logic [31:2] addr, input logic [31:4] base);
    return (addr[31:4] == base) && (addr[3:2] != 2'b11);
  endfunction

endpackage

// File: rtl/pr_bridge_timer.sv
// pr_timer: three-register interval timer (CTRL, PRESET, COUNT) with a
// one-shot / auto-reload FSM and a maskable interrupt flag.
module pr_timer
  import pr_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  tmr_state_e  state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic ctrl_we;
  logic preset_we;
  logic en;
  logic auto_mode;

  assign ctrl_we   = WE && (Addr == OFF_CTRL);
  assign preset_we = WE && (Addr == OFF_PRESET);
  assign en        = ctrl_q[CTRL_EN];
  assign auto_mode = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_AUTO);
  assign IRQ       = ctrl_q[CTRL_IM] & irq_flag_q;

  // Register read mux; COUNT is read-only and offset 3 reads zero
  always_comb begin
    RD = 32'h0;
    case (Addr)
      OFF_CTRL:   RD = {28'h0, ctrl_q};
      OFF_PRESET: RD = preset_q;
      OFF_COUNT:  RD = count_q;
      default:    RD = 32'h0;
    endcase
  end

  // Next-state: software writes first, then the FSM; the FSM only clears
  // Enable when no CTRL write lands in the same cycle, and a firing INT
  // re-sets the flag so an interrupt is never lost to a coincident write.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    if (ctrl_we) begin
      ctrl_d     = WD[3:0];
      irq_flag_d = 1'b0;
    end
    if (preset_we) begin
      preset_d = WD;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
        // Auto-reload flag is a single-cycle pulse ending here
        if (auto_mode) irq_flag_d = 1'b0;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'h0;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        irq_flag_d = 1'b1;
        if (auto_mode) begin
          state_d = ST_LOAD;
        end else begin
          if (!ctrl_we) ctrl_d[CTRL_EN] = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register update with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'h0;
      preset_q   <= 32'h0;
      count_q    <= 32'h0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

endmodule

// File: rtl/pr_bridge.sv
// pr_bridge: CPU-side address decode, read mux and interrupt wiring for
// the internal timer and one external device window.
// Build option: define PR_BRIDGE_DEV_EN to decode the external device
// window; without it the Dev ports are tied off and the window reads 0.
module pr_bridge
  import pr_bridge_pkg::*;
#(
  parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEF,
  parameter logic [31:0] DEV_BASE   = DEV_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        PrWE,
  output logic [31:0] PrRD,
  output logic [7:2]  HWInt,
  output logic [1:0]  DevAddr,
  output logic [31:0] DevWD,
  output logic        DevWE,
  input  logic [31:0] DevRD,
  input  logic        DevInt
);

  logic        tmr_hit;
  logic        dev_hit;
  logic        tmr_irq;
  logic        dev_irq;
  logic [31:0] tmr_rd;
  logic        addr_unused;

  // Byte-lane bits play no part in word decode
  assign addr_unused = ^PrAddr[1:0];

  assign tmr_hit = win_hit(PrAddr[31:2], TIMER_BASE[31:4]);

`ifdef PR_BRIDGE_DEV_EN
  assign dev_hit = win_hit(PrAddr[31:2], DEV_BASE[31:4]);
  assign DevAddr = PrAddr[3:2];
  assign DevWD   = PrWD;
  assign DevWE   = PrWE & dev_hit & ~reset;
  assign dev_irq = DevInt;
`else
  logic dev_unused;
  assign dev_unused = ^{DevRD, DevInt, DEV_BASE};
  assign dev_hit    = 1'b0;
  assign DevAddr    = 2'b00;
  assign DevWD      = 32'h0;
  assign DevWE      = 1'b0;
  assign dev_irq    = 1'b0;
`endif

  pr_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .Addr  (PrAddr[3:2]),
    .WE    (PrWE & tmr_hit),
    .WD    (PrWD),
    .RD    (tmr_rd),
    .IRQ   (tmr_irq)
  );

  // Read mux from the current address; unmapped reads return zero
  always_comb begin
    PrRD = 32'h0;
    if (tmr_hit) begin
      PrRD = tmr_rd;
    end else if (dev_hit) begin
      PrRD = DevRD;
    end
  end

  // Interrupt lines, forced low while reset is held
  always_comb begin
    HWInt = 6'b0;
    if (!reset) begin
      HWInt[2] = tmr_irq;
      HWInt[3] = dev_irq;
    end
  end

endmodule

// File: tb/tb_pr_bridge.sv
// Directed bench for pr_bridge: timer one-shot, auto-reload, disable,
// minimum preset, unmapped accesses, device window and async reset.
module tb_pr_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic [31:0] PrRD;
  logic [7:2]  HWInt;
  logic [1:0]  DevAddr;
  logic [31:0] DevWD;
  logic        DevWE;
  logic [31:0] DevRD;
  logic        DevInt;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_TGAP   = 32'h0000_7F0C;
  localparam logic [31:0] A_DEV    = 32'h0000_7F10;
  localparam logic [31:0] A_DGAP   = 32'h0000_7F1C;
  localparam logic [31:0] DEV_DATA = 32'hCAFE_F00D;

  always #5 clk = ~clk;

  pr_bridge dut (
    .clk     (clk),
    .reset   (reset),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrWE    (PrWE),
    .PrRD    (PrRD),
    .HWInt   (HWInt),
    .DevAddr (DevAddr),
    .DevWD   (DevWD),
    .DevWE   (DevWE),
    .DevRD   (DevRD),
    .DevInt  (DevInt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    PrAddr = a;
    PrWD   = d;
    PrWE   = 1'b1;
    @(posedge clk);
    #1;
    PrWE = 1'b0;
  endtask

  task automatic rd_next(input logic [31:0] a);
    @(negedge clk);
    PrAddr = a;
    PrWE   = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    PrWE   = 1'b0;
    DevInt = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset  = 1'b1;
    DevInt = 1'b1;
    PrAddr = A_DEV + 32'd4;
    PrWD   = 32'h1234;
    PrWE   = 1'b1;
    #1;
    n_run++;
    if (HWInt !== 6'b0) begin
      n_fail++; $display("FAIL reset_hwint: got %b expected %b", HWInt, 6'b0);
    end
    n_run++;
    if (DevWE !== 1'b0) begin
      n_fail++; $display("FAIL reset_devwe: got %b expected 0", DevWE);
    end
    PrWE = 1'b0;
    PrAddr = A_CTRL; #1;
    n_run++;
    if (PrRD !== 32'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected 0", PrRD);
    end
    PrAddr = A_PRESET; #1;
    n_run++;
    if (PrRD !== 32'h0) begin
      n_fail++; $display("FAIL reset_preset: got %h expected 0", PrRD);
    end
    PrAddr = A_COUNT; #1;
    n_run++;
    if (PrRD !== 32'h0) begin
      n_fail++; $display("FAIL reset_count: got %h expected 0", PrRD);
    end
    @(negedge clk);
    reset  = 1'b0;
    DevInt = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [31:0] exp_cnt [6];
    exp_cnt = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
    do_reset();
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 6; k++) begin
      rd_next(A_COUNT);
      n_run++;
      if (PrRD !== exp_cnt[k]) begin
        n_fail++; $display("FAIL oneshot_count[%0d]: got %0d expected %0d", k, PrRD, exp_cnt[k]);
      end
    end
    n_run++;
    if (HWInt !== 6'b0) begin
      n_fail++; $display("FAIL oneshot_irq_early: got %b expected %b", HWInt, 6'b0);
    end
    for (int k = 0; k < 3; k++) begin
      rd_next(A_CTRL);
      n_run++;
      if (HWInt !== 6'b000001) begin
        n_fail++; $display("FAIL oneshot_irq_hold[%0d]: got %b expected %b", k, HWInt, 6'b000001);
      end
    end
    n_run++;
    if (PrRD !== 32'h8) begin
      n_fail++; $display("FAIL oneshot_ctrl: got %h expected 8", PrRD);
    end
  endtask

  task automatic test_autoreload();
    logic exp_irq;
    do_reset();
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk); #1;
      exp_irq = (k >= 6) && (((k - 6) % 4) == 0);
      n_run++;
      if (HWInt[2] !== exp_irq) begin
        n_fail++; $display("FAIL auto_irq[%0d]: got %b expected %b", k, HWInt[2], exp_irq);
      end
    end
  endtask

  task automatic test_disable();
    bit found;
    found = 1'b0;
    do_reset();
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 20 && !found; k++) begin
      rd_next(A_COUNT);
      if (PrRD === 32'd6) found = 1'b1;
    end
    n_run++;
    if (!found) begin
      n_fail++; $display("FAIL disable_reach6: got %0d expected 6", PrRD);
    end
    PrAddr = A_CTRL;
    PrWD   = 32'h8;
    PrWE   = 1'b1;
    @(posedge clk); #1;
    PrWE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_next(A_COUNT);
      n_run++;
      if (PrRD !== 32'd5) begin
        n_fail++; $display("FAIL disable_hold[%0d]: got %0d expected 5", k, PrRD);
      end
      n_run++;
      if (HWInt !== 6'b0) begin
        n_fail++; $display("FAIL disable_noirq[%0d]: got %b expected %b", k, HWInt, 6'b0);
      end
    end
  endtask

  task automatic test_unmapped();
    rd_next(A_TGAP);
    n_run++;
    if (PrRD !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_tgap: got %h expected 0", PrRD);
    end
    rd_next(A_DGAP);
    n_run++;
    if (PrRD !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_dgap: got %h expected 0", PrRD);
    end
    rd_next(32'h0000_8F00);
    n_run++;
    if (PrRD !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_far: got %h expected 0", PrRD);
    end
    wr(A_COUNT, 32'h1);
    wr(A_TGAP, 32'hF);
    rd_next(A_COUNT);
    n_run++;
    if (PrRD !== 32'd5) begin
      n_fail++; $display("FAIL count_write_dropped: got %0d expected 5", PrRD);
    end
    rd_next(A_CTRL);
    n_run++;
    if (PrRD !== 32'h8) begin
      n_fail++; $display("FAIL gap_write_dropped: got %h expected 8", PrRD);
    end
  endtask

  task automatic test_preset_min();
    for (int p = 0; p < 2; p++) begin
      do_reset();
      wr(A_PRESET, p);
      wr(A_CTRL, 32'h9);
      repeat (3) @(negedge clk);
      @(negedge clk); #1;
      n_run++;
      if (HWInt[2] !== 1'b0) begin
        n_fail++; $display("FAIL presetmin_early[%0d]: got %b expected 0", p, HWInt[2]);
      end
      @(negedge clk); #1;
      n_run++;
      if (HWInt[2] !== 1'b1) begin
        n_fail++; $display("FAIL presetmin_fire[%0d]: got %b expected 1", p, HWInt[2]);
      end
    end
  endtask

  task automatic test_device();
    logic [31:0] exp_wd, exp_rd;
    logic        exp_we;
    logic [1:0]  exp_addr;
    logic [7:2]  exp_int;
`ifdef PR_BRIDGE_DEV_EN
    exp_we = 1'b1; exp_addr = 2'd2; exp_wd = 32'hDEAD; exp_int = 6'b000010; exp_rd = DEV_DATA;
`else
    exp_we = 1'b0; exp_addr = 2'd0; exp_wd = 32'h0; exp_int = 6'b000000; exp_rd = 32'h0;
`endif
    do_reset();
    DevInt = 1'b1;
    @(negedge clk);
    PrAddr = A_DEV + 32'd8;
    PrWD   = 32'hDEAD;
    PrWE   = 1'b1;
    #1;
    n_run++;
    if (DevWE !== exp_we) begin
      n_fail++; $display("FAIL dev_we: got %b expected %b", DevWE, exp_we);
    end
    n_run++;
    if (DevAddr !== exp_addr) begin
      n_fail++; $display("FAIL dev_addr: got %0d expected %0d", DevAddr, exp_addr);
    end
    n_run++;
    if (DevWD !== exp_wd) begin
      n_fail++; $display("FAIL dev_wd: got %h expected %h", DevWD, exp_wd);
    end
    n_run++;
    if (HWInt !== exp_int) begin
      n_fail++; $display("FAIL dev_hwint: got %b expected %b", HWInt, exp_int);
    end
    @(posedge clk); #1;
    PrWE = 1'b0;
    rd_next(A_DEV + 32'd4);
    n_run++;
    if (DevWE !== 1'b0) begin
      n_fail++; $display("FAIL dev_we_oneshot: got %b expected 0", DevWE);
    end
    n_run++;
    if (PrRD !== exp_rd) begin
      n_fail++; $display("FAIL dev_read: got %h expected %h", PrRD, exp_rd);
    end
    DevInt = 1'b0;
    #1;
    n_run++;
    if (HWInt !== 6'b0) begin
      n_fail++; $display("FAIL dev_int_low: got %b expected %b", HWInt, 6'b0);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    DevInt = 1'b1;
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    repeat (6) @(negedge clk);
    PrAddr = A_PRESET;
    #1;
    n_run++;
    if (HWInt[2] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre_irq: got %b expected 1", HWInt[2]);
    end
    reset = 1'b1;
    #1;
    n_run++;
    if (HWInt !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_hwint: got %b expected %b", HWInt, 6'b0);
    end
    n_run++;
    if (PrRD !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_preset: got %h expected 0", PrRD);
    end
    PrAddr = A_CTRL;
    #1;
    n_run++;
    if (PrRD !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got %h expected 0", PrRD);
    end
    @(negedge clk);
    reset  = 1'b0;
    DevInt = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    PrAddr = 32'h0;
    PrWD   = 32'h0;
    PrWE   = 1'b0;
    DevRD  = DEV_DATA;
    DevInt = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_oneshot();
    test_autoreload();
    test_disable();
    test_unmapped();
    test_preset_min();
    test_device();
    test_reset_midcount();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
